// File: rtl/demux_pkg.sv
// Shared types for the 4-way streaming demux: channel select encoding and output-stage states.
package demux_pkg;
    typedef logic [1:0] demux_sel_t;

    localparam demux_sel_t CH_A = 2'd0;
    localparam demux_sel_t CH_B = 2'd1;
    localparam demux_sel_t CH_C = 2'd2;
    localparam demux_sel_t CH_D = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stage_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible combinationally for the popping stage.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural binary rollover.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/demux_stream_x4.sv
// Buffered 1-to-4 stream demux: input FIFO, one-entry output register, per-channel valid/ready.
// Optional DEMUX_STREAM_RR_EN assigns destinations round-robin at push time instead of using in_sel.
module demux_stream_x4
    import demux_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BUS_WIDTH-1:0]          in_data,
    input  logic [1:0]                    in_sel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [BUS_WIDTH-1:0]          a,
    output logic [BUS_WIDTH-1:0]          b,
    output logic [BUS_WIDTH-1:0]          c,
    output logic [BUS_WIDTH-1:0]          d,
    output logic [3:0]                    out_valid,
    input  logic [3:0]                    out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int EW = BUS_WIDTH + 2;

    stage_state_t         state_q;
    demux_sel_t           sel_q;
    logic [BUS_WIDTH-1:0] data_q;

    demux_sel_t           dest_sel;
    logic [EW-1:0]        head_word;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [BUS_WIDTH-1:0] ch_data [4];

    // No full-bypass: readiness depends only on the registered occupancy.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = !fifo_empty && ((state_q == ST_IDLE) || out_ready[sel_q]);

`ifdef DEMUX_STREAM_RR_EN
    demux_sel_t rr_q;
    logic       unused_in_sel;

    assign unused_in_sel = ^in_sel;
    assign dest_sel      = rr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= CH_A;
        end else if (push) begin
            rr_q <= rr_q + 1'b1;
        end
    end
`else
    assign dest_sel = in_sel;
`endif

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({dest_sel, in_data}),
        .pop       (pop),
        .head_data (head_word),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pop and load share one edge, so a HOLD with an accept and a non-empty FIFO stays in HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= CH_A;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        sel_q   <= head_word[EW-1:BUS_WIDTH];
                        data_q  <= head_word[BUS_WIDTH-1:0];
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready[sel_q]) begin
                        if (pop) begin
                            sel_q  <= head_word[EW-1:BUS_WIDTH];
                            data_q <= head_word[BUS_WIDTH-1:0];
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        assign out_valid[gi] = (state_q == ST_HOLD) && (sel_q == demux_sel_t'(gi));
        assign ch_data[gi]   = out_valid[gi] ? data_q : '0;
    end

    assign a = ch_data[CH_A];
    assign b = ch_data[CH_B];
    assign c = ch_data[CH_C];
    assign d = ch_data[CH_D];
endmodule

// File: tb/tb_demux_stream_x4.sv
// Scoreboard bench for demux_stream_x4: directed scenarios plus randomized traffic against an in-order queue model.
module tb_demux_stream_x4;
    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
    } word_t;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b, c, d;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [2:0] count;

    int    vectors     = 0;
    int    miscompares = 0;
    int    rr_model    = 0;
    word_t exp_q[$];

    demux_stream_x4 #(.BUS_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: every accepted word is delivered once, in push order, to its destination.
    task automatic model_push(input logic [1:0] s, input logic [7:0] dat);
        word_t w;
`ifdef DEMUX_STREAM_RR_EN
        w.sel = 2'(rr_model % 4);
        rr_model++;
`else
        w.sel = s;
`endif
        w.data = dat;
        exp_q.push_back(w);
        $display("push sel=%0d data=%02h -> expect ch %0d", s, dat, w.sel);
    endtask

    task automatic send(input logic [1:0] s, input logic [7:0] dat);
        logic acc;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = dat;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                model_push(s, dat);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Monitor: compares every presented word with the queue head and retires it on accept.
    always @(negedge clk) begin
        logic [7:0] ch [4];
        word_t      e;
        int         holding;
        if (!reset) begin
            ch      = '{a, b, c, d};
            holding = (out_valid != 4'b0) ? 1 : 0;
            chk("occupancy", int'(count) + holding, exp_q.size());
            chk("in_ready", int'(in_ready), (count < 3'd4) ? 1 : 0);
            if (holding == 1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", int'(out_valid), 0);
                end else begin
                    e = exp_q[0];
                    chk("out_valid", int'(out_valid), 1 << e.sel);
                    for (int k = 0; k < 4; k++) begin
                        chk("chan_data", int'(ch[k]), (k == int'(e.sel)) ? int'(e.data) : 0);
                    end
                    if ((out_valid & out_ready) != 4'b0) begin
                        $display("deliver ch=%0d data=%02h", e.sel, e.data);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("idle_zero", int'(a | b | c | d), 0);
            end
        end
    end

    task automatic drain();
        out_ready = 4'hF;
        in_valid  = 1'b0;
        for (int t = 0; t < 40 && (exp_q.size() != 0 || out_valid != 4'b0); t++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic       acc;
        logic [3:0] v0;
        logic [7:0] c0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        out_ready = 4'h0;
        reset     = 1'b1;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_data", int'(a | b | c | d), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single word to channel c, one-cycle latency, idle again after accept.
        out_ready = 4'hF;
        send(2'd2, 8'hA5);
        @(negedge clk);
        chk("t1_latency_valid", int'(out_valid), 0);
        @(negedge clk);
        chk("t1_valid", int'(out_valid), 4'b0100);
        chk("t1_c", int'(c), 8'hA5);
        @(negedge clk);
        chk("t1_idle", int'(out_valid), 0);
        @(posedge clk); #1;

        // Stall all consumers, fill the FIFO, confirm backpressure and stable hold.
        out_ready = 4'h0;
        send(2'd1, 8'h11);
        send(2'd3, 8'h22);
        send(2'd0, 8'h33);
        send(2'd2, 8'h44);
        send(2'd1, 8'h55);
        @(negedge clk);
        chk("t2_full_count", int'(count), 4);
        chk("t2_in_ready", int'(in_ready), 0);
        v0 = out_valid;
        c0 = a | b | c | d;
        repeat (10) begin
            @(negedge clk);
            chk("t2_hold_valid", int'(out_valid), int'(v0));
            chk("t2_hold_data", int'(a | b | c | d), int'(c0));
        end
        @(posedge clk); #1;
        out_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_count_seq", int'(count), 4 - i);
        end
        drain();

        // Head-of-line blocking on a stalled channel b.
        out_ready = 4'b1101;
        send(2'd1, 8'h66);
        send(2'd0, 8'h77);
        repeat (5) begin
            @(negedge clk);
            chk("t4_block_valid", int'(out_valid), 4'b0010);
            chk("t4_block_count", int'(count), 1);
        end
        drain();

        // Asynchronous reset while holding with three queued words.
        out_ready = 4'h0;
        send(2'd0, 8'h81);
        send(2'd1, 8'h82);
        send(2'd2, 8'h83);
        send(2'd3, 8'h84);
        #2;
        chk("t5_pre_count", int'(count), 3);
        reset = 1'b1;
        #1;
        chk("t5_async_valid", int'(out_valid), 0);
        chk("t5_async_count", int'(count), 0);
        chk("t5_async_ready", int'(in_ready), 1);
        exp_q.delete();
        rr_model = 0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Six words all requesting channel d.
        out_ready = 4'hF;
        for (int i = 0; i < 6; i++) send(2'd3, 8'(8'hC0 + i));
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) model_push(in_sel, in_data);
            #1;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
